// File: rtl/mul_pkg.sv
// mul_pkg: shared widths, iteration count and enums for the sequential
// RV32M multiplier (mul_seq).
package mul_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ITER = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/rca.sv
// rca: n-bit ripple-carry adder, no carry-in, sum only. The carry out of
// the top bit is reconstructed by the caller from the operand/sum MSBs.
module rca #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] sum
);

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    logic cy;
    cy = 1'b0;
    for (int i = 0; i < n; i++) begin
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential 32x32 shift-and-add multiplier for MUL/MULH/MULHSU/
// MULHU. Operands are reduced to magnitudes, multiplied unsigned over 32
// iterations of one shared adder, and the sign is restored in FIX.
// Optional feature macro: MUL_EARLY_EXIT_EN (skip iterations once the
// remaining multiplier bits are all zero).
import mul_pkg::*;

module mul_seq (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state;
  op_e               op_q;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [CNT_W-1:0]  cnt;
  logic              neg;

  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   addend;
  logic [XLEN-1:0]   sum;
  logic              carry;
  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod_fix;
  logic              last_iter;

  // Two's complement negation; -0x80000000 wraps to 0x80000000, which is
  // the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] x);
    logic signed [XLEN-1:0] s;
    s = x;
    return XLEN'(-s);
  endfunction

  function automatic logic [2*XLEN-1:0] neg64(input logic [2*XLEN-1:0] x);
    logic signed [2*XLEN-1:0] s;
    s = x;
    return (2*XLEN)'(-s);
  endfunction

  // Operand sign selection for the incoming request.
  always_comb begin
    sa = ((op_e'(op) == MULH) || (op_e'(op) == MULHSU)) && a[XLEN-1];
    sb = (op_e'(op) == MULH) && b[XLEN-1];
  end

  assign addend = acc_lo[0] ? mcand : '0;

  rca #(.n(XLEN)) u_rca (
    .a   (acc_hi),
    .b   (addend),
    .sum (sum)
  );

  // Adder carry-out rebuilt from the MSBs of both addends and the sum.
  assign carry = (acc_hi[XLEN-1] & addend[XLEN-1]) |
                 ((acc_hi[XLEN-1] ^ addend[XLEN-1]) & ~sum[XLEN-1]);

`ifdef MUL_EARLY_EXIT_EN
  logic [CNT_W-1:0] shamt;
  logic [XLEN-1:0]  rem_mask;
  logic [XLEN-1:0]  rem_bits;

  // Multiplier bits not yet consumed after this cycle's shift; once they
  // are all zero, the rest of the iterations would only shift.
  always_comb begin
    rem_mask  = 32'h7FFF_FFFF >> cnt;
    rem_bits  = {1'b0, acc_lo[XLEN-1:1]} & rem_mask;
    last_iter = (cnt == CNT_W'(ITERS - 1)) || (rem_bits == '0);
  end

  // Align a short product: the skipped shifts are applied in one step.
  always_comb begin
    shamt    = CNT_W'(ITERS) - cnt;
    prod_raw = {acc_hi, acc_lo} >> shamt;
  end
`else
  // Fixed iteration count: the product is already aligned in FIX.
  always_comb begin
    last_iter = (cnt == CNT_W'(ITERS - 1));
    prod_raw  = {acc_hi, acc_lo};
  end
`endif

  assign prod_fix = neg ? neg64(prod_raw) : prod_raw;

  // Controller FSM with shift register, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= MUL;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op_e'(op);
            mcand  <= sa ? neg32(a) : a;
            acc_lo <= sb ? neg32(b) : b;
            acc_hi <= '0;
            cnt    <= '0;
            neg    <= sa ^ sb;
            busy   <= 1'b1;
            state  <= ITER;
          end
        end
        ITER: begin
          {acc_hi, acc_lo} <= {carry, sum, acc_lo[XLEN-1:1]};
          cnt              <= cnt + 1'b1;
          if (last_iter) state <= FIX;
        end
        FIX: begin
          {acc_hi, acc_lo} <= prod_fix;
          result           <= (op_q == MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
          done             <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: table-driven and random checks of mul_seq with a result
// scoreboard queue, plus ignored-start and mid-operation reset sequences.
module tb_mul_seq;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] expq[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  mul_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Independent reference: sign/zero extend and multiply at 66 bits.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] ex;
    logic signed [65:0] ey;
    logic signed [65:0] p;
    ex = (o == 2'b01 || o == 2'b10) ? {{34{x[31]}}, x} : {34'b0, x};
    ey = (o == 2'b01) ? {{34{y[31]}}, y} : {34'b0, y};
    p  = ex * ey;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
`ifdef MUL_EARLY_EXIT_EN
    logic [31:0] mag;
    int k;
    mag = (o == 2'b01 && y[31]) ? (~y + 32'd1) : y;
    k = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
    return k + 2;
`else
    return 34;
`endif
  endfunction

  task automatic quiet(input int n);
    int d;
    d = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) d++;
    end
    check("no_extra_done", d, 0);
  endtask

  // One operation: start at edge 0, inputs scrambled afterwards, optional
  // ignored start (inj) or reset (rc) at the given cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] e, input int inj, input int rc);
    int lat;
    int cyc;
    logic [31:0] want;
    lat = exp_lat(o, y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    expq.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    cyc = 1;
    while (!done && cyc < 40) begin
      check("busy_mid", {31'b0, busy}, 1);
      if (cyc == rc) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", result, 0);
        want = expq.pop_front();
        quiet(40);
        return;
      end
      if (cyc == inj) begin
        start = 1'b1; op = 2'b11; a = '1; b = '1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    want = expq.pop_front();
    if (!done) begin
      check("done_timeout", {31'b0, done}, 1);
      return;
    end
    check("latency", cyc, lat);
    check("busy_at_done", {31'b0, busy}, 1);
    check("result", result, want);
    @(posedge clk); #1;
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_done", {31'b0, done}, 0);
    check("result_hold", result, want);
    if (inj > 0) quiet(40);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int inj;

    tbl[0] = '{2'b00, 32'd7,         32'd6,         32'h0000_002A};
    tbl[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[3] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[4] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[5] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[6] = '{2'b00, 32'd5,         32'd3,         32'h0000_000F};
    tbl[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    tbl[8] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[9] = '{2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_result", result, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 0, 0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i < 4) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), 0, 0);
    end

    inj = (exp_lat(2'b10, 32'd2) > 10) ? 10 : 2;
    run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, inj, 0);

    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), 0, 15);
    run_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
